ref_mem_loader: RTL and testbench

- Write-side front end for the 32-bank reference memory.
- Accepts reference rows of 32 pixels (one row per beat) over a valid/ready stream and drives the memory write interface: 256-bit data, one-hot-group bank select and 32 per-bank 7-bit write addresses.
- Loads a programmable number of 8-row groups into a circular address space of DEPTH entries, starting at a programmable base address. This supports sliding search-window refills.

---
 rtl/ref_mem_pkg.sv | 43 ++++
 rtl/ref_addr_gen.sv | 75 +++++++
 rtl/ref_mem_loader.sv | 154 +++++++++++++++
 tb/tb_ref_mem_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ref_mem_pkg.sv
// Shared constants, FSM state type and address helpers for the
// reference-memory write front end.
package ref_mem_pkg;

  localparam int PIXEL          = 8;
  localparam int NBANK          = 32;
  localparam int BANKS_PER_ROW  = 4;
  localparam int ROWS_PER_GROUP = 8;
  localparam int DEPTH          = 96;
  localparam int AW             = 7;
  localparam int RW             = 3;              // row index width (0..7)
  localparam int ROW_BITS       = NBANK * PIXEL;  // one 32-pixel row

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_e;

  // Circular increment over 0..DEPTH-1.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    if (a == AW'(DEPTH - 1)) begin
      r = 7'd0;
    end else begin
      r = a + 7'd1;
    end
    return r;
  endfunction

  // Folds an out-of-range start address back into 0..DEPTH-1.
  function automatic logic [AW-1:0] addr_norm(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    if (a >= AW'(DEPTH)) begin
      r = a - AW'(DEPTH);
    end else begin
      r = a;
    end
    return r;
  endfunction

endpackage

// File: rtl/ref_addr_gen.sv
// Row / group counters for the reference loader: tracks the row inside
// the current 8-row group, the circular group address and the number of
// groups still to load, and flags the final beat of the load.
module ref_addr_gen
  import ref_mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] num_groups,
  output logic [RW-1:0] row_idx,
  output logic [AW-1:0] grp_addr,
  output logic          last
);

  logic [RW-1:0] row_cnt_r;
  logic [AW-1:0] grp_addr_r;
  logic [AW-1:0] grp_left_r;

  logic [RW-1:0] row_cnt_nx_s;
  logic [AW-1:0] grp_addr_nx_s;
  logic [AW-1:0] grp_left_nx_s;
  logic          row_end_s;

  assign row_end_s = (row_cnt_r == 3'd7);
  assign last      = row_end_s && (grp_left_r == 7'd1);
  assign row_idx   = row_cnt_r;
  assign grp_addr  = grp_addr_r;

  // Next-value selection: new load, per-beat advance with group wrap, or hold.
  always_comb begin
    row_cnt_nx_s  = row_cnt_r;
    grp_addr_nx_s = grp_addr_r;
    grp_left_nx_s = grp_left_r;
    if (load) begin
      row_cnt_nx_s  = 3'd0;
      grp_addr_nx_s = addr_norm(start_addr);
      if (num_groups == 7'd0) begin
        grp_left_nx_s = 7'd1;
      end else begin
        grp_left_nx_s = num_groups;
      end
    end else if (advance) begin
      if (row_end_s) begin
        row_cnt_nx_s  = 3'd0;
        grp_addr_nx_s = addr_inc(grp_addr_r);
        grp_left_nx_s = grp_left_r - 7'd1;
      end else begin
        row_cnt_nx_s  = row_cnt_r + 3'd1;
        grp_addr_nx_s = grp_addr_r;
        grp_left_nx_s = grp_left_r;
      end
    end else begin
      row_cnt_nx_s  = row_cnt_r;
      grp_addr_nx_s = grp_addr_r;
      grp_left_nx_s = grp_left_r;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt_r  <= 3'd0;
      grp_addr_r <= 7'd0;
      grp_left_r <= 7'd0;
    end else begin
      row_cnt_r  <= row_cnt_nx_s;
      grp_addr_r <= grp_addr_nx_s;
      grp_left_r <= grp_left_nx_s;
    end
  end

endmodule

// File: rtl/ref_mem_loader.sv
// Write-side front end for the 32-bank reference memory. Accepts one
// 32-pixel row per beat and turns it into a registered bank write: the
// four banks of the current row are enabled and given the group address.
module ref_mem_loader
  import ref_mem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [AW-1:0]          start_addr,
  input  logic [AW-1:0]          num_groups,
  input  logic [ROW_BITS-1:0]    in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ROW_BITS-1:0]    ref_input,
  output logic [NBANK-1:0]       Bank_sel,
  output logic [NBANK*AW-1:0]    write_address_all,
  output logic                   busy,
  output logic                   load_done
);

  ld_state_e state_r;
  ld_state_e state_nx_s;

  logic                grp_load_s;
  logic                accept_s;
  logic                in_ready_s;
  logic [RW-1:0]       row_idx_s;
  logic [AW-1:0]       grp_addr_s;
  logic                last_s;
  logic [NBANK-1:0]    bank_sel_s;

  logic [ROW_BITS-1:0] ref_input_r;
  logic [NBANK-1:0]    bank_sel_r;
  logic [NBANK*AW-1:0] wa_r;
  logic                busy_r;
  logic                load_done_r;

  ref_addr_gen u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (grp_load_s),
    .advance    (accept_s),
    .start_addr (start_addr),
    .num_groups (num_groups),
    .row_idx    (row_idx_s),
    .grp_addr   (grp_addr_s),
    .last       (last_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state, ready and beat acceptance. DONE is the load_done cycle;
  // keeping it separate from IDLE makes a start coinciding with
  // load_done get ignored.
  always_comb begin
    state_nx_s = state_r;
    grp_load_s = 1'b0;
    accept_s   = 1'b0;
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          grp_load_s = 1'b1;
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          accept_s = 1'b1;
          if (last_s) begin
            state_nx_s = ST_FLUSH;
          end else begin
            state_nx_s = ST_LOAD;
          end
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        state_nx_s = ST_DONE;
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Bank enables for the current row: four adjacent banks per row.
  always_comb begin
    bank_sel_s = 32'h0000_0000;
    if (accept_s) begin
      bank_sel_s = 32'h0000_000F << {row_idx_s, 2'b00};
    end else begin
      bank_sel_s = 32'h0000_0000;
    end
  end

  // Registered write drive: data, enables and per-bank addresses.
  // Unselected bank addresses keep their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_input_r <= 256'd0;
      bank_sel_r  <= 32'd0;
      wa_r        <= 224'd0;
    end else begin
      bank_sel_r <= bank_sel_s;
      if (accept_s) begin
        ref_input_r <= in_data;
      end else begin
        ref_input_r <= ref_input_r;
      end
      for (int j = 0; j < NBANK; j++) begin
        if (bank_sel_s[j]) begin
          wa_r[j*AW +: AW] <= grp_addr_s;
        end else begin
          wa_r[j*AW +: AW] <= wa_r[j*AW +: AW];
        end
      end
    end
  end

  // Status flags, registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r      <= 1'b0;
      load_done_r <= 1'b0;
    end else begin
      busy_r      <= (state_nx_s == ST_LOAD) || (state_nx_s == ST_FLUSH);
      load_done_r <= (state_nx_s == ST_DONE);
    end
  end

  assign in_ready          = in_ready_s;
  assign ref_input         = ref_input_r;
  assign Bank_sel          = bank_sel_r;
  assign write_address_all = wa_r;
  assign busy              = busy_r;
  assign load_done         = load_done_r;

endmodule

// File: tb/tb_ref_mem_loader.sv
// Scoreboard bench for ref_mem_loader: the driver pushes the expected
// bank write for every accepted beat, the monitor pops and compares
// whenever Bank_sel shows a write.
module tb_ref_mem_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [6:0]   start_addr;
  logic [6:0]   num_groups;
  logic [255:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] ref_input;
  logic [31:0]  Bank_sel;
  logic [223:0] write_address_all;
  logic         busy;
  logic         load_done;

  typedef struct {
    logic [31:0]  sel;
    logic [6:0]   addr;
    logic [255:0] data;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           tests_run = 0;
  int           tests_failed = 0;
  int           nwr = 0;
  logic [223:0] exp_wa;
  logic [63:0]  exp_slice;
  bit           slice_mode = 1'b0;

  ref_mem_loader dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .start_addr        (start_addr),
    .num_groups        (num_groups),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .ref_input         (ref_input),
    .Bank_sel          (Bank_sel),
    .write_address_all (write_address_all),
    .busy              (busy),
    .load_done         (load_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] row_data(input int mode, input int g, input int r);
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 32; k++) begin
      case (mode)
        0:       d[8*k +: 8] = 8'(r);
        1:       d[8*k +: 8] = 8'(k);
        default: d[8*k +: 8] = 8'(g*37 + r*11 + k);
      endcase
    end
    return d;
  endfunction

  // Monitor: every write shown on Bank_sel must match the head of the queue.
  always @(negedge clk) begin
    if (Bank_sel !== 32'd0) begin
      nwr++;
      if (q.size() == 0) begin
        chk("unexpected_write", {224'd0, Bank_sel}, 256'd0);
      end else begin
        mon_e = q.pop_front();
        chk("bank_sel", {224'd0, Bank_sel}, {224'd0, mon_e.sel});
        chk("ref_input", ref_input, mon_e.data);
        for (int j = 0; j < 32; j++) begin
          if (mon_e.sel[j]) exp_wa[j*7 +: 7] = mon_e.addr;
        end
        chk("write_address_all", {32'd0, write_address_all}, {32'd0, exp_wa});
        if (slice_mode) begin
          for (int m = 0; m < 4; m++) begin
            for (int p = 0; p < 8; p++) exp_slice[8*p +: 8] = 8'(8*m + p);
            chk("bank_slice", {192'd0, ref_input[64*m +: 64]}, {192'd0, exp_slice});
          end
        end
      end
    end
  end

  task automatic run_load(input logic [6:0] sa, input logic [6:0] ng, input int base_exp,
                          input int n_exp, input bit bubble, input int mode,
                          input bit mid_start, input bit done_start, input int abort_after);
    int   beats;
    int   guard;
    bit   got;
    bit   bub;
    bit   seen;
    time  t0;
    exp_t e;
    nwr   = 0;
    beats = (abort_after > 0) ? abort_after : 8 * n_exp;
    @(negedge clk);
    start = 1'b1; start_addr = sa; num_groups = ng; in_valid = 1'b0;
    t0  = $time;
    bub = 1'b0;
    for (int b = 0; b < beats; b++) begin
      got = 1'b0; guard = 0;
      while (!got && guard < 40) begin
        @(negedge clk);
        start = 1'b0;
        guard++;
        if (mid_start && b == 3 && guard == 1) begin
          start = 1'b1; start_addr = 7'd3; num_groups = 7'd5;
        end
        if (bubble && bub) begin
          in_valid = 1'b0;
          bub = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data  = row_data(mode, b / 8, b % 8);
          #1;
          if (in_ready) begin
            e.sel  = 32'h0000_000F << (4 * (b % 8));
            e.addr = 7'((base_exp + b / 8) % 96);
            e.data = in_data;
            q.push_back(e);
            got = 1'b1;
            if (bubble) bub = 1'b1;
          end
        end
      end
      if (!got) chk("accept_timeout", 256'd0, 256'd1);
    end
    if (abort_after > 0) return;
    @(negedge clk);
    chk("busy_flush", {255'd0, busy}, 256'd1);
    chk("ready_flush", {255'd0, in_ready}, 256'd0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (load_done === 1'b1) seen = 1'b1;
    end
    chk("load_done_seen", {255'd0, seen}, 256'd1);
    if (seen) begin
      if (!bubble) chk("done_latency", 256'(($time - t0) / 10), 256'(8 * n_exp + 2));
      chk("busy_at_done", {255'd0, busy}, 256'd0);
    end
    in_valid = 1'b0;
    if (done_start) begin
      start = 1'b1; start_addr = 7'd0; num_groups = 7'd1;
      @(negedge clk);
      start = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("busy_after", {255'd0, busy}, 256'd0);
    chk("ready_idle", {255'd0, in_ready}, 256'd0);
    chk("done_pulse", {255'd0, load_done}, 256'd0);
    chk("write_count", 256'(nwr), 256'(8 * n_exp));
    chk("queue_empty", 256'(q.size()), 256'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = 7'd0; num_groups = 7'd0;
    in_data = 256'd0; in_valid = 1'b0; exp_wa = 224'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {255'd0, in_ready}, 256'd0);
    chk("rst_ref_input", ref_input, 256'd0);
    chk("rst_bank_sel", {224'd0, Bank_sel}, 256'd0);
    chk("rst_waddr", {32'd0, write_address_all}, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_load_done", {255'd0, load_done}, 256'd0);
    rst = 1'b0;

    // in_valid while IDLE is never accepted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = row_data(2, 9, i);
      #1;
      chk("idle_ready", {255'd0, in_ready}, 256'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("idle_bank_sel", {224'd0, Bank_sel}, 256'd0);
    chk("idle_busy", {255'd0, busy}, 256'd0);

    // single group at address 0, row index replicated
    run_load(7'd0, 7'd1, 0, 1, 1'b0, 0, 1'b0, 1'b0, 0);
    // wrap-around: groups at 94, 95, 0
    run_load(7'd94, 7'd3, 94, 3, 1'b0, 2, 1'b0, 1'b0, 0);
    // bubbles on in_valid, two groups
    run_load(7'd20, 7'd2, 20, 2, 1'b1, 2, 1'b0, 1'b0, 0);
    // start during LOAD and start coinciding with load_done are ignored
    run_load(7'd40, 7'd1, 40, 1, 1'b0, 2, 1'b1, 1'b1, 0);
    // pixel k = k slicing; start_addr 100 folds to 4, num_groups 0 loads one group
    slice_mode = 1'b1;
    run_load(7'd100, 7'd0, 4, 1, 1'b0, 1, 1'b0, 1'b0, 0);
    slice_mode = 1'b0;

    // reset after five accepted beats
    run_load(7'd60, 7'd2, 60, 2, 1'b0, 2, 1'b0, 1'b0, 5);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("abort_bank_sel", {224'd0, Bank_sel}, 256'd0);
    chk("abort_ref_input", ref_input, 256'd0);
    chk("abort_waddr", {32'd0, write_address_all}, 256'd0);
    chk("abort_busy", {255'd0, busy}, 256'd0);
    chk("abort_load_done", {255'd0, load_done}, 256'd0);
    chk("abort_in_ready", {255'd0, in_ready}, 256'd0);
    chk("abort_writes", 256'(nwr), 256'd5);
    chk("abort_queue", 256'(q.size()), 256'd0);
    rst = 1'b0;
    exp_wa = 224'd0;
    // a load after the abort behaves normally
    run_load(7'd7, 7'd1, 7, 1, 1'b0, 0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
